dna_reader: RTL and testbench

Reads one network's genome out of external cellular RAM through the RAM controller's client handshake and streams it, word by word, to the network evaluator. It is the read-side counterpart of the DNA initializer, which writes genomes through the same handshake. It sits between the RAM controller and the network block in the top level, and is started by network control when a network is activated.

---
 rtl/dna_reader_pkg.sv | 19 +
 rtl/dna_reader_gene_fifo2.sv | 53 +++++
 rtl/dna_reader.sv | 126 ++++++++++++
 tb/tb_dna_reader.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dna_reader_pkg.sv
// Shared definitions for the genome reader: RAM opcodes, FSM encoding and
// genome geometry defaults.
package dna_reader_pkg;

   localparam logic RAM_READ  = 1'b0;
   localparam logic RAM_WRITE = 1'b1;

   localparam int GENOME_LOG2 = 6;
   localparam int NET_W       = 4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE   = 3'd1,
      ST_WAIT_LO = 3'd2,
      ST_WAIT_HI = 3'd3,
      ST_FLUSH   = 3'd4
   } state_t;

endpackage

// File: rtl/dna_reader_gene_fifo2.sv
// Two-entry synchronous FIFO; push and pop in the same cycle are legal at any
// occupancy, including full.
module gene_fifo2 #(
   parameter int W = 17
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic [W-1:0] i_data,
   output logic [W-1:0] o_data,
   output logic         o_full,
   output logic         o_empty
);

   logic [W-1:0] r_mem [2];
   logic         r_rd_ptr;
   logic         r_wr_ptr;
   logic [1:0]   r_count;
   logic         w_push;
   logic         w_pop;

   assign w_pop   = i_pop && (r_count != 2'd0);
   assign w_push  = i_push && ((r_count != 2'd2) || w_pop);
   assign o_data  = r_mem[r_rd_ptr];
   assign o_full  = (r_count == 2'd2);
   assign o_empty = (r_count == 2'd0);

   // When full, the write slot is the head being popped in the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/dna_reader.sv
// Reads one genome from cellular RAM via the controller client handshake and
// streams it to the network evaluator through a 2-deep buffer.
//   state    | meaning
//   IDLE     | waiting for start
//   ISSUE    | latch next read once RAM is ready and a buffer slot is free
//   WAIT_LO  | waiting for the controller to drop ram_ready
//   WAIT_HI  | waiting for read data (ram_ready high again)
//   FLUSH    | last word read, draining buffer before done
module dna_reader #(
   parameter int                ADDR_W      = 23,
   parameter int                DATA_W      = 16,
   parameter int                GENOME_LOG2 = dna_reader_pkg::GENOME_LOG2,
   parameter int                NET_W       = dna_reader_pkg::NET_W,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [NET_W-1:0]  net_idx,
   output logic              busy,
   output logic              done,
   output logic              ram_instruction,
   output logic              ram_latch,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [DATA_W-1:0] ram_data,
   input  logic              ram_ready,
   output logic [DATA_W-1:0] gene_data,
   output logic              gene_valid,
   input  logic              gene_ready,
   output logic              gene_last
);
   import dna_reader_pkg::*;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [ADDR_W-1:0]      r_base;
   logic [GENOME_LOG2-1:0] r_word_idx;
   logic [ADDR_W-1:0]      w_base_nxt;
   logic                   w_last_word;
   logic                   w_latch;
   logic                   w_push;
   logic                   w_done;
   logic                   w_full;
   logic                   w_empty;
   logic                   w_slot_free;
   logic [DATA_W:0]        w_fifo_out;

   assign w_base_nxt  = BASE_ADDR + (ADDR_W'(net_idx) << GENOME_LOG2);
   assign w_last_word = (r_word_idx == '1);
   // A pop in this cycle frees a slot even when the buffer is currently full.
   assign w_slot_free = !w_full || gene_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_latch     = 1'b0;
      w_push      = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) w_state_nxt = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (ram_ready && w_slot_free) begin
               w_latch     = 1'b1;
               w_state_nxt = ST_WAIT_LO;
            end
         end
         ST_WAIT_LO: begin
            if (!ram_ready) w_state_nxt = ST_WAIT_HI;
         end
         ST_WAIT_HI: begin
            if (ram_ready) begin
               w_push      = 1'b1;
               w_state_nxt = w_last_word ? ST_FLUSH : ST_ISSUE;
            end
         end
         ST_FLUSH: begin
            if (w_empty) begin
               w_done      = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_base     <= '0;
         r_word_idx <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_IDLE && start) begin
            r_base     <= w_base_nxt;
            r_word_idx <= '0;
         end else if (w_push) begin
            r_word_idx <= r_word_idx + 1'b1;
         end
      end
   end

   gene_fifo2 #(
      .W (DATA_W + 1)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (gene_ready),
      .i_data  ({w_last_word, ram_data}),
      .o_data  (w_fifo_out),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // RAM outputs are zero outside ISSUE so the top level can OR clients together.
   assign ram_instruction = RAM_READ;
   assign ram_latch       = w_latch;
   assign ram_addr        = (r_state == ST_ISSUE) ? (r_base + ADDR_W'(r_word_idx)) : '0;
   assign busy            = (r_state != ST_IDLE);
   assign done            = w_done;
   assign gene_valid      = !w_empty;
   assign gene_data       = w_fifo_out[DATA_W-1:0];
   assign gene_last       = !w_empty && w_fifo_out[DATA_W];

endmodule

// File: tb/tb_dna_reader.sv
// Bench for dna_reader: two instances (base 0 and a wrapping base) share one
// model RAM controller with latency 3; a queue model predicts addresses and words.
module tb_dna_reader;
   import dna_reader_pkg::*;

   localparam int LAT = 3;

   typedef struct {
      logic        dut;
      int          net;
      int          rmode;
      logic        extra;
      logic [22:0] first;
      logic [22:0] last;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_a = 1'b0, start_b = 1'b0;
   logic [3:0]  net_idx = '0;
   logic        gene_ready = 1'b0;
   logic        sel = 1'b0;
   logic        busy_a, done_a, instr_a, latch_a, gvalid_a, glast_a;
   logic        busy_b, done_b, instr_b, latch_b, gvalid_b, glast_b;
   logic [22:0] addr_a, addr_b, w_addr;
   logic [15:0] gdata_a, gdata_b;
   logic        w_latch, w_instr, ram_ready;
   logic [15:0] ram_data;
   logic        a_busy, a_done, a_valid, a_last, o_done;
   logic [15:0] a_data;

   int          ctl_d = 0;
   logic [15:0] ctl_word = '0;
   logic        ctl_extra = 1'b0;
   logic        lat_seen = 1'b0;
   logic [22:0] lat_addr = '0;
   logic [15:0] salt = '0;

   int          n_pass = 0, n_total = 0;
   int          cyc = 0, last_hs_cyc = -10, done_cnt = 0, rdy_mode = 0;
   logic        stall_prev = 1'b0, prev_last = 1'b0;
   logic [15:0] prev_data = '0;
   logic [22:0] exp_addr_q[$];
   logic [16:0] exp_q[$];
   logic [22:0] lat_log[$];
   vec_t        vecs[6];

   always #5 clk = ~clk;

   dna_reader u_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .net_idx(net_idx),
      .busy(busy_a), .done(done_a), .ram_instruction(instr_a), .ram_latch(latch_a),
      .ram_addr(addr_a), .ram_data(ram_data), .ram_ready(ram_ready),
      .gene_data(gdata_a), .gene_valid(gvalid_a), .gene_ready(gene_ready & ~sel),
      .gene_last(glast_a)
   );

   dna_reader #(.BASE_ADDR(23'h7FFFF0)) u_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .net_idx(net_idx),
      .busy(busy_b), .done(done_b), .ram_instruction(instr_b), .ram_latch(latch_b),
      .ram_addr(addr_b), .ram_data(ram_data), .ram_ready(ram_ready),
      .gene_data(gdata_b), .gene_valid(gvalid_b), .gene_ready(gene_ready & sel),
      .gene_last(glast_b)
   );

   assign w_latch = latch_a | latch_b;
   assign w_addr  = addr_a | addr_b;
   assign w_instr = instr_a | instr_b;
   assign a_busy  = sel ? busy_b : busy_a;
   assign a_done  = sel ? done_b : done_a;
   assign o_done  = sel ? done_a : done_b;
   assign a_valid = sel ? gvalid_b : gvalid_a;
   assign a_last  = sel ? glast_b : glast_a;
   assign a_data  = sel ? gdata_b : gdata_a;

   function automatic logic [15:0] mem_word(input logic [22:0] a);
      return a[15:0] ^ {a[22:16], 9'h0} ^ salt;
   endfunction

   // Model controller: ready drops after a latch, data valid when it returns.
   // It is not reset by rst_n, so an in-flight read simply completes.
   assign ram_ready = (ctl_d == 0) || (ctl_extra && ctl_d == LAT - 1);
   assign ram_data  = (ctl_d == 0) ? ctl_word : 16'hDEAD;

   always @(posedge clk) begin
      if (lat_seen) begin
         ctl_d    <= LAT - 1;
         ctl_word <= mem_word(lat_addr);
      end else if (ctl_d > 0) begin
         ctl_d <= ctl_d - 1;
      end
   end

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic tick();
      logic [16:0] e;
      logic [22:0] ea;
      @(negedge clk);
      cyc++;
      lat_seen = w_latch;
      lat_addr = w_addr;
      if (w_latch) begin
         check_eq("latch_needs_ready", ram_ready, 1'b1);
         check_eq("ram_instruction", w_instr, RAM_READ);
         lat_log.push_back(w_addr);
         if (exp_addr_q.size() > 0) begin
            ea = exp_addr_q.pop_front();
            check_eq("ram_addr", w_addr, ea);
         end else begin
            check_eq("unexpected_latch", w_latch, 1'b0);
         end
      end
      if (stall_prev && a_valid) begin
         check_eq("stall_data_stable", a_data, prev_data);
         check_eq("stall_last_stable", a_last, prev_last);
      end
      if (a_valid && gene_ready) begin
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("gene_data", a_data, e[15:0]);
            check_eq("gene_last", a_last, e[16]);
            if (e[16]) last_hs_cyc = cyc;
         end else begin
            check_eq("unexpected_word", a_valid, 1'b0);
         end
      end
      stall_prev = a_valid && !gene_ready;
      prev_data  = a_data;
      prev_last  = a_last;
      if (a_done) begin
         done_cnt++;
         check_eq("done_timing", cyc, last_hs_cyc + 1);
      end
      if (o_done) check_eq("idle_dut_done", o_done, 1'b0);
      @(posedge clk);
      #1;
      if (rdy_mode == 1) gene_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic fill_expect(input logic s, input int n);
      logic [22:0] a;
      int          base;
      exp_q.delete();
      exp_addr_q.delete();
      lat_log.delete();
      base = s ? 32'h7FFFF0 : 0;
      for (int i = 0; i < 64; i++) begin
         a = 23'((base + n * 64 + i) % (1 << 23));
         exp_addr_q.push_back(a);
         exp_q.push_back({(i == 63), mem_word(a)});
      end
   endtask

   task automatic pulse_start(input logic s, input int n);
      net_idx = 4'(n);
      if (s) start_b = 1'b1;
      else   start_a = 1'b1;
      tick();
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic wait_done(input int d0, input string name);
      int b = 0;
      while (done_cnt == d0 && b < 3000) begin
         tick();
         b++;
      end
      check_eq(name, done_cnt, d0 + 1);
   endtask

   task automatic check_range(input logic [22:0] first, input logic [22:0] last);
      check_eq("latch_count", lat_log.size(), 64);
      if (lat_log.size() == 64) begin
         check_eq("first_addr", lat_log[0], first);
         check_eq("last_addr", lat_log[63], last);
      end
      check_eq("words_left", exp_q.size(), 0);
   endtask

   task automatic run_vec(input vec_t v);
      int d0;
      sel        = v.dut;
      ctl_extra  = v.extra;
      rdy_mode   = v.rmode;
      gene_ready = 1'b1;
      stall_prev = 1'b0;
      fill_expect(v.dut, v.net);
      d0 = done_cnt;
      pulse_start(v.dut, v.net);
      check_eq("busy_after_start", a_busy, 1'b1);
      wait_done(d0, "done_seen");
      check_range(v.first, v.last);
      tick();
      check_eq("busy_after_done", a_busy, 1'b0);
      check_eq("idle_ram_addr", w_addr, 23'd0);
      rdy_mode = 0;
   endtask

   initial begin
      int   b;
      int   d0;
      vec_t rv;
      salt = 16'($urandom);
      vecs[0] = '{1'b0,  2, 0, 1'b0, 23'd128,     23'd191};
      vecs[1] = '{1'b0,  5, 1, 1'b1, 23'd320,     23'd383};
      vecs[2] = '{1'b0, 15, 1, 1'b0, 23'd960,     23'd1023};
      vecs[3] = '{1'b1,  0, 0, 1'b0, 23'h7FFFF0,  23'h00002F};
      vecs[4] = '{1'b1,  1, 1, 1'b1, 23'h000030,  23'h00006F};
      vecs[5] = '{1'b1, 15, 1, 1'b0, 23'h0003B0,  23'h0003EF};

      repeat (3) tick();
      check_eq("rst_busy", {busy_a, busy_b}, 2'b00);
      check_eq("rst_done", {done_a, done_b}, 2'b00);
      check_eq("rst_latch", w_latch, 1'b0);
      check_eq("rst_addr", w_addr, 23'd0);
      check_eq("rst_valid", {gvalid_a, gvalid_b}, 2'b00);
      check_eq("rst_last", {glast_a, glast_b}, 2'b00);
      check_eq("rst_data", {gdata_a, gdata_b}, 32'd0);
      rst_n = 1'b1;
      repeat (2) tick();

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Downstream stall with an early word, then a start while busy.
      sel = 1'b0; ctl_extra = 1'b0; rdy_mode = 0; gene_ready = 1'b0; stall_prev = 1'b0;
      fill_expect(1'b0, 2);
      d0 = done_cnt;
      pulse_start(1'b0, 2);
      b = 0;
      while (!gvalid_a && b < 200) begin tick(); b++; end
      check_eq("first_word_seen", gvalid_a, 1'b1);
      repeat (20) tick();
      check_eq("stall_latches", lat_log.size(), 2);
      check_eq("stall_valid", gvalid_a, 1'b1);
      gene_ready = 1'b1;
      repeat (30) tick();
      pulse_start(1'b0, 5);
      check_eq("busy_ignores_start", busy_a, 1'b1);
      wait_done(d0, "stall_done_seen");
      check_range(23'd128, 23'd191);
      tick();

      // Reset while waiting for read data with one word buffered.
      gene_ready = 1'b0; stall_prev = 1'b0;
      fill_expect(1'b0, 3);
      pulse_start(1'b0, 3);
      b = 0;
      while (lat_log.size() < 2 && b < 200) begin tick(); b++; end
      check_eq("second_latch_seen", lat_log.size(), 2);
      tick();
      check_eq("pre_rst_valid", gvalid_a, 1'b1);
      check_eq("pre_rst_ready", ram_ready, 1'b0);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_busy", busy_a, 1'b0);
      check_eq("mid_rst_valid", gvalid_a, 1'b0);
      check_eq("mid_rst_last", glast_a, 1'b0);
      check_eq("mid_rst_data", gdata_a, 16'd0);
      check_eq("mid_rst_latch", latch_a, 1'b0);
      check_eq("mid_rst_addr", addr_a, 23'd0);
      check_eq("mid_rst_done", done_a, 1'b0);
      exp_q.delete();
      exp_addr_q.delete();
      stall_prev = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (2) tick();
      rv = '{1'b0, 3, 0, 1'b0, 23'd192, 23'd255};
      run_vec(rv);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
